// File: rtl/tri_skew_pkg.sv
// Shared types and helpers for the triangular skew/deskew buffer.
//   mode_e  : lane delay mode (SKEW delays lane k by k, DESKEW by N-1-k)
//   state_e : control FSM states
//   lane_delay(k, m, n) : delay of lane k in mode m for an n-lane array
//   lane_depth(k, n)    : registers lane k needs to serve both modes
package tri_skew_pkg;

  typedef enum logic {
    SKEW   = 1'b0,
    DESKEW = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int lane_delay(input int k, input mode_e m, input int n);
    return (m == DESKEW) ? (n - 1 - k) : k;
  endfunction

  function automatic int lane_depth(input int k, input int n);
    return (k > (n - 1 - k)) ? k : (n - 1 - k);
  endfunction

endpackage

// File: rtl/tri_skew_lane.sv
// One lane of the skew buffer: a data+valid shift register deep enough for
// both modes, with a tap mux that picks the skew or deskew delay.
// A delay of 0 is a combinational passthrough of din/vin.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   advance      : shift enable for this cycle
//   mode         : applied mode (0 skew, 1 deskew)
//   din, vin     : lane input data / valid (vin already qualified by accept)
//   dout, vout   : tap data / tap valid
//   v_any        : any valid register set now
//   v_any_next   : any valid register set after this cycle's edge
module tri_skew_lane
  import tri_skew_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int N_SIZE    = 16,
  parameter int K         = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 advance,
  input  logic                 mode,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 vin,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 vout,
  output logic                 v_any,
  output logic                 v_any_next
);

  localparam int DEPTH = lane_depth(K, N_SIZE);

  logic [DEPTH-1:0][DATAWIDTH-1:0] dreg;
  logic [DEPTH-1:0]                vreg;
  logic [DEPTH-1:0]                vnext;
  logic [1:0][DATAWIDTH-1:0]       tap_d;
  logic [1:0]                      tap_v;

  always_comb begin
    vnext = vreg;
    if (advance) begin
      vnext[0] = vin;
      for (int i = 1; i < DEPTH; i++) vnext[i] = vreg[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vreg <= '0;
    end else begin
      vreg <= vnext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dreg <= '0;
    end else if (advance) begin
      dreg[0] <= din;
      for (int i = 1; i < DEPTH; i++) dreg[i] <= dreg[i-1];
    end
  end

  // Both taps are fixed at elaboration; register index d-1 holds data
  // accepted d advances ago.
  for (genvar m = 0; m < 2; m++) begin : g_tap
    localparam int D = lane_delay(K, (m == 0) ? SKEW : DESKEW, N_SIZE);
    if (D == 0) begin : g_pass
      assign tap_d[m] = din;
      assign tap_v[m] = vin;
    end else begin : g_reg
      assign tap_d[m] = dreg[D-1];
      assign tap_v[m] = vreg[D-1];
    end
  end

  assign dout       = mode ? tap_d[1] : tap_d[0];
  assign vout       = mode ? tap_v[1] : tap_v[0];
  assign v_any      = |vreg;
  assign v_any_next = |vnext;

endmodule

// File: rtl/tri_skew_buffer.sv
// Triangular skew/deskew register array for systolic psum lanes.
// Lane k is delayed k cycles (skew) or N_SIZE-1-k cycles (deskew), with a
// shift-enable stall, per-lane valids, deferred mode switching and a flush
// state that drains the array with zero bubbles.
// Optional build macro TRI_SKEW_OUT_REG_EN adds a register on every output
// lane (latency +1, flush one cycle longer).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   shift_en    : advance enable (ignored during flush)
//   mode        : requested mode, applied only when idle and empty
//   in_valid    : psum_in valid;  in_ready : low during flush
//   psum_in     : N_SIZE lanes of DATAWIDTH bits
//   flush       : drain request;  flush_done : pulse in last flush cycle
//   psum_out    : tap data per lane;  out_valid : per-lane qualifier
//   busy        : data in flight or flushing;  mode_active : applied mode
module tri_skew_buffer
  import tri_skew_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int N_SIZE    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              shift_en,
  input  logic                              mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [N_SIZE-1:0][DATAWIDTH-1:0]  psum_in,
  input  logic                              flush,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]  psum_out,
  output logic [N_SIZE-1:0]                 out_valid,
  output logic                              busy,
  output logic                              mode_active,
  output logic                              flush_done
);

  localparam int MAXD = N_SIZE - 1;
`ifdef TRI_SKEW_OUT_REG_EN
  localparam int FLUSH_LEN = MAXD + 1;
`else
  localparam int FLUSH_LEN = MAXD;
`endif
  localparam int CNTW = $clog2(FLUSH_LEN + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FLUSH_LEN - 1);

  state_e                           state;
  logic [CNTW-1:0]                  cnt;
  logic                             mode_q;
  logic                             advance;
  logic                             accept;
  logic                             empty;
  logic                             empty_next;
  logic [N_SIZE-1:0]                v_any;
  logic [N_SIZE-1:0]                v_any_next;
  logic [N_SIZE-1:0]                tap_v;
  logic [N_SIZE-1:0][DATAWIDTH-1:0] tap_d;

  assign in_ready    = (state != FLUSH);
  assign advance     = (state == FLUSH) || shift_en;
  assign accept      = in_valid && in_ready && advance;
  assign empty       = ~|v_any;
  assign empty_next  = ~|v_any_next;
  assign busy        = !empty || (state == FLUSH);
  assign mode_active = mode_q;

  // During flush the lanes see zero data with no valid.
  for (genvar k = 0; k < N_SIZE; k++) begin : g_lane
    tri_skew_lane #(
      .DATAWIDTH(DATAWIDTH),
      .N_SIZE   (N_SIZE),
      .K        (k)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .mode      (mode_q),
      .din       (in_ready ? psum_in[k] : '0),
      .vin       (accept),
      .dout      (tap_d[k]),
      .vout      (tap_v[k]),
      .v_any     (v_any[k]),
      .v_any_next(v_any_next[k])
    );
  end

`ifdef TRI_SKEW_OUT_REG_EN
  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_out  <= '0;
      out_valid <= '0;
    end else begin
      psum_out  <= tap_d;
      out_valid <= tap_v & {N_SIZE{advance}};
    end
  end
`else
  assign psum_out  = tap_d;
  assign out_valid = tap_v & {N_SIZE{advance}};
`endif

  // Control FSM. A mode change is only taken while idle and empty so data
  // already in flight keep the delays they were accepted with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (state == IDLE && empty && !accept) mode_q <= mode;
          if (flush) begin
            state      <= FLUSH;
            cnt        <= '0;
            flush_done <= (FLUSH_LEN == 1);
          end else if (accept) begin
            state <= RUN;
          end else if (state == RUN && advance && empty_next) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt        <= cnt + 1'b1;
            flush_done <= ((cnt + 1'b1) == CNT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_skew_buffer.sv
module tb_tri_skew_buffer;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int MAXD = N - 1;
`ifdef TRI_SKEW_OUT_REG_EN
  localparam int FLUSH_LEN = MAXD + 1;
`else
  localparam int FLUSH_LEN = MAXD;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   shift_en;
  logic                   mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0][DW-1:0]   psum_in;
  logic                   flush;
  logic [N-1:0][DW-1:0]   psum_out;
  logic [N-1:0]           out_valid;
  logic                   busy;
  logic                   mode_active;
  logic                   flush_done;

  int checks   = 0;
  int failures = 0;

  tri_skew_buffer #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (shift_en),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .psum_in    (psum_in),
    .flush      (flush),
    .psum_out   (psum_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .mode_active(mode_active),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: every advance records what the lanes were offered.
  // A lane with delay d shows the record made d advances ago.
  logic [N-1:0][DW-1:0] hd [64];
  logic                 hv [64];
  int                   cnt_adv;
  bit                   m_run;
  int                   m_fleft;
  bit                   m_mode;
  bit                   m_adv, m_rdy, m_acc, m_empty;
  logic [N-1:0][DW-1:0] c_d, o_d;
  logic [N-1:0]         c_v, o_v;

  function automatic bit hist_empty(input int now);
    bit e = 1'b1;
    for (int a = 1; a <= MAXD; a++) if (hv[(now - a) & 63]) e = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      hd[i] = '0;
      hv[i] = 1'b0;
    end
    cnt_adv = 0; m_run = 0; m_fleft = 0; m_mode = 0;
    o_d = '0; o_v = '0;
  endtask

  task automatic model_comb();
    int d, e;
    m_adv   = (m_fleft > 0) || shift_en;
    m_rdy   = (m_fleft == 0);
    m_acc   = in_valid && m_rdy && m_adv;
    m_empty = hist_empty(cnt_adv);
    for (int k = 0; k < N; k++) begin
      d = m_mode ? (N - 1 - k) : k;
      if (d == 0) begin
        c_d[k] = m_rdy ? psum_in[k] : '0;
        c_v[k] = m_acc;
      end else begin
        e = (cnt_adv - d) & 63;
        c_d[k] = hd[e][k];
        c_v[k] = hv[e] && m_adv;
      end
    end
  endtask

  task automatic model_update();
    if (m_adv) begin
      hd[cnt_adv & 63] = m_rdy ? psum_in : '0;
      hv[cnt_adv & 63] = m_acc;
      cnt_adv++;
    end
    if (m_fleft > 0) begin
      m_fleft--;
      if (m_fleft == 0) m_run = 0;
    end else begin
      if (!m_run && m_empty && !m_acc) m_mode = mode;
      if (flush) m_fleft = FLUSH_LEN;
      else if (m_acc) m_run = 1;
      else if (m_run && m_adv && hist_empty(cnt_adv)) m_run = 0;
    end
    o_d = c_d;
    o_v = c_v;
  endtask

  typedef struct {
    bit       iv, se, fl, md;
    int       dc;
    bit [3:0] ov;
    bit       bz, rdy, fd, ma;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit iv, se, fl, md, input int dc, input bit [3:0] ov,
                              input bit bz, rdy, fd, ma);
    vec_t v;
    v.iv = iv; v.se = se; v.fl = fl; v.md = md; v.dc = dc;
    v.ov = ov; v.bz = bz; v.rdy = rdy; v.fd = fd; v.ma = ma;
    return v;
  endfunction

  task automatic cycle(input bit use_row, input vec_t r);
    @(negedge clk);
    model_comb();
`ifdef TRI_SKEW_OUT_REG_EN
    chk("psum_out", psum_out, o_d);
    chk("out_valid", 64'(out_valid), 64'(o_v));
`else
    chk("psum_out", psum_out, c_d);
    chk("out_valid", 64'(out_valid), 64'(c_v));
`endif
    chk("busy", 64'(busy), 64'(!m_empty || m_fleft > 0));
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("mode_active", 64'(mode_active), 64'(m_mode));
    chk("flush_done", 64'(flush_done), 64'(m_fleft == 1));
    if (use_row) begin
      chk("tbl_out_valid", 64'(out_valid), 64'(r.ov));
      chk("tbl_busy", 64'(busy), 64'(r.bz));
      chk("tbl_in_ready", 64'(in_ready), 64'(r.rdy));
      chk("tbl_flush_done", 64'(flush_done), 64'(r.fd));
      chk("tbl_mode_active", 64'(mode_active), 64'(r.ma));
      for (int k = 0; k < N; k++)
        if (r.ov[k]) chk("tbl_lane_data", 64'(psum_out[k]), 64'(10 * (k + 1)));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_cycles(input int n);
    vec_t dummy;
    dummy = mk(0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      shift_en = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      for (int k = 0; k < N; k++) psum_in[k] = DW'($urandom);
      cycle(1'b0, dummy);
    end
  endtask

  initial begin
    rst_n = 1'b0; shift_en = 1'b0; mode = 1'b0; in_valid = 1'b0;
    flush = 1'b0; psum_in = '0;
    model_reset();
    #2;
    chk("rst_psum_out", psum_out, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mode_active", 64'(mode_active), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // skew
    tbl.push_back(mk(1,1,0,0,1, 4'b0001, 0,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b0010, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b0100, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b1000, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0,1,0,0));
    // stall in cycles 1-2
    tbl.push_back(mk(1,1,0,0,1, 4'b0001, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'b0000, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'b0000, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b0010, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b0100, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b1000, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0,1,0,0));
    // flush at cycle 1, shift_en low and in_valid high while flushing
    tbl.push_back(mk(1,1,0,0,1, 4'b0001, 0,1,0,0));
    tbl.push_back(mk(0,1,1,0,0, 4'b0010, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,2, 4'b0100, 1,0,0,0));
    tbl.push_back(mk(1,0,1,0,2, 4'b1000, 1,0,0,0));
    tbl.push_back(mk(1,0,0,0,2, 4'b0000, 1,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0,1,0,0));
    // deskew, then back to skew
    tbl.push_back(mk(0,1,0,1,0, 4'b0000, 0,1,0,0));
    tbl.push_back(mk(1,1,0,1,1, 4'b1000, 0,1,0,1));
    tbl.push_back(mk(0,1,0,1,0, 4'b0100, 1,1,0,1));
    tbl.push_back(mk(0,1,0,1,0, 4'b0010, 1,1,0,1));
    tbl.push_back(mk(0,1,0,1,0, 4'b0001, 1,1,0,1));
    tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0,1,0,1));
    tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0,1,0,0));
    // mode change requested while busy is deferred
    tbl.push_back(mk(1,1,0,0,1, 4'b0001, 0,1,0,0));
    tbl.push_back(mk(0,1,0,1,0, 4'b0010, 1,1,0,0));
    tbl.push_back(mk(0,1,0,1,0, 4'b0100, 1,1,0,0));
    tbl.push_back(mk(0,1,0,1,0, 4'b1000, 1,1,0,0));
    tbl.push_back(mk(0,1,0,1,0, 4'b0000, 0,1,0,0));
    tbl.push_back(mk(1,1,0,1,1, 4'b1000, 0,1,0,1));
    tbl.push_back(mk(0,1,0,1,0, 4'b0100, 1,1,0,1));
    tbl.push_back(mk(0,1,0,1,0, 4'b0010, 1,1,0,1));
    tbl.push_back(mk(0,1,0,1,0, 4'b0001, 1,1,0,1));
    tbl.push_back(mk(0,1,0,1,0, 4'b0000, 0,1,0,1));

`ifndef TRI_SKEW_OUT_REG_EN
    foreach (tbl[i]) begin
      in_valid = tbl[i].iv;
      shift_en = tbl[i].se;
      flush    = tbl[i].fl;
      mode     = tbl[i].md;
      for (int k = 0; k < N; k++)
        psum_in[k] = (tbl[i].dc == 1) ? DW'(10 * (k + 1)) :
                     (tbl[i].dc == 2) ? DW'(99) : '0;
      cycle(1'b1, tbl[i]);
    end
`endif

    rand_cycles(1200);

    // asynchronous reset in the middle of traffic
    in_valid = 1'b0; psum_in = '0; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_psum_out", psum_out, 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_mode_active", 64'(mode_active), 64'd0);
    chk("midrst_flush_done", 64'(flush_done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = 1'b0;

    rand_cycles(1200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_skew_buffer.md
Name: tri_skew_buffer

Overview:
- Parametrised triangular skew/deskew register array for systolic-array partial-sum lanes; generalises the fixed 16-lane shift-down logic to any lane count.
- Lane k is delayed by a mode-dependent number of cycles: skew mode delays k, deskew mode delays N_SIZE-1-k.
- Adds a shift-enable stall, per-lane valid tracking, runtime mode select and a flush/drain state machine.
- Sits between the PE array psum outputs and the accumulator/output buffer.

Parameters:
DATAWIDTH, 32, psum lane width in bits
N_SIZE, 16, number of lanes (>=2); maximum delay is N_SIZE-1
MAXD, N_SIZE-1 (derived localparam), flush length and deepest tap

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
shift_en  in  1  advance enable; low = stall (flush overrides)
mode  in  1  requested mode: 0 = skew (delay k), 1 = deskew (delay N_SIZE-1-k)
in_valid  in  1  psum_in vector valid
in_ready  out  1  high except in FLUSH
psum_in  in  DATAWIDTH x N_SIZE  input lanes
flush  in  1  one-cycle drain request
psum_out  out  DATAWIDTH x N_SIZE  delayed lanes
out_valid  out  N_SIZE  per-lane output qualifier
busy  out  1  pipeline non-empty or flushing
mode_active  out  1  mode currently applied (mode_q)
flush_done  out  1  one-cycle pulse at end of flush

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. Reset clears all delay and valid registers to 0, state to IDLE, and mode_q, flush_done and busy to 0.
- Lane structure: each lane k holds max(k, N_SIZE-1-k) data+valid registers with a tap mux selecting delay d_k from mode_q.
- Zero-delay lane: d_k=0 is a combinational passthrough of psum_in[k]/in_valid.
- advance = shift_en in IDLE/RUN; advance = 1 in FLUSH. Registers shift only when advance is high and hold otherwise.
- Accept: in_valid accepted only when in_ready && advance. A valid in_valid with in_ready high and advance low is dropped (stall must be honoured upstream).
- out_valid[k] = tap_valid_k && advance; the consumer samples on the same edge. psum_out[k] shows the tap data regardless of valid.
- Latency: lane k emits exactly d_k advance cycles after acceptance. Stalls extend wall-clock latency without corrupting data.
- empty = all valid registers 0.
- FSM states and transitions:
  IDLE -> RUN on an accepted input.
  RUN -> IDLE when empty after a shift with no accept.
  IDLE/RUN -> FLUSH on flush.
  FLUSH -> IDLE after MAXD cycles.
- FLUSH: in_ready=0; zeros with valid=0 are shifted in; a 0..MAXD-1 counter runs; flush_done pulses in the cycle the counter reaches MAXD-1. A flush received during FLUSH is ignored.
- Flush and in_valid in the same cycle: the input is accepted, and FLUSH starts the next cycle.
- Flush while shift_en=0: the flush proceeds regardless.
- mode_q loads from mode only in IDLE with empty and no accept this cycle. A mode change while non-empty is deferred until empty; data in flight keep their delays.
- busy = !empty || state==FLUSH.

Optional Feature:
- Macro: TRI_SKEW_OUT_REG_EN.
- When defined: one extra register stage on every psum_out/out_valid lane, with no combinational path. Every latency grows by 1, the flush length becomes MAXD+1 cycles, and flush_done pulses one cycle later.
- When undefined: behaviour as above, including the combinational zero-delay lane.

Decomposition:
- Package tri_skew_pkg:
  - mode enum (SKEW=0, DESKEW=1)
  - FSM state enum (IDLE, RUN, FLUSH)
  - function lane_delay(k, mode, n)
  - function lane_depth(k, n) = max(k, n-1-k)
- Sub-module tri_skew_lane: one lane's data+valid shift register of parametrised depth, with tap mux, advance and reset.
- The top level contains the generate loop over lanes, the FSM, the flush counter and mode_q.

Test Plan:
- Reset: assert rst_n=0 mid-traffic -> all psum_out=0, out_valid=0, busy=0, mode_active=0 immediately; state IDLE after release.
- Skew, N_SIZE=4, shift_en=1: {10,20,30,40} valid at cycle 0 -> lane0 =10 valid at cycle 0, lane1 =20 at cycle 1, lane2 =30 at cycle 2, lane3 =40 at cycle 3; busy falls after cycle 3.
- Deskew, N_SIZE=4: same input -> lane3 =40 at cycle 0, lane2 at 1, lane1 at 2, lane0 =10 at 3.
- Stall: skew mode, shift_en=0 in cycles 1-2 -> lane1 at cycle 3, lane3 at cycle 5, values unchanged, no out_valid during stall.
- Flush: input at cycle 0, flush at cycle 1 -> in_ready=0 in cycles 2-4, remaining lanes emitted, flush_done at cycle 4, IDLE at cycle 5; in_valid during FLUSH is not accepted.
- Mode deferral: mode 0->1 while busy -> mode_active stays 0 until empty, then becomes 1; the next vector follows deskew delays.
